// File: rtl/logit_frame_buffer_pkg.sv
// Shared sizes and presenter state encoding for the logit frame buffer.
package logit_frame_buffer_pkg;

    localparam int N_LOGITS = 10;
    localparam int DATA_W   = 16;
    localparam int CNT_W    = 4;

    localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(N_LOGITS - 1);

    typedef enum logic {
        P_IDLE = 1'b0,
        P_WAIT = 1'b1
    } pstate_e;

endpackage

// File: rtl/logit_frame_buffer_if.sv
// Serial logit stream in, parallel frame plus valid/done handshake out.
interface logit_frame_buffer_if;
    import logit_frame_buffer_pkg::*;

    logic              in_valid;
    logic              in_ready;
    logic [DATA_W-1:0] in_data;
    logic              in_last;
    logic [DATA_W-1:0] logit0;
    logic [DATA_W-1:0] logit1;
    logic [DATA_W-1:0] logit2;
    logic [DATA_W-1:0] logit3;
    logic [DATA_W-1:0] logit4;
    logic [DATA_W-1:0] logit5;
    logic [DATA_W-1:0] logit6;
    logic [DATA_W-1:0] logit7;
    logic [DATA_W-1:0] logit8;
    logic [DATA_W-1:0] logit9;
    logic              valid_out;
    logic              done_in;
    logic              frame_err;

    // Upstream producer / downstream consumer side.
    modport master (
        output in_valid, in_data, in_last, done_in,
        input  in_ready, valid_out, frame_err,
        input  logit0, logit1, logit2, logit3, logit4,
        input  logit5, logit6, logit7, logit8, logit9
    );

    // Buffer side.
    modport slave (
        input  in_valid, in_data, in_last, done_in,
        output in_ready, valid_out, frame_err,
        output logit0, logit1, logit2, logit3, logit4,
        output logit5, logit6, logit7, logit8, logit9
    );

endinterface

// File: rtl/logit_frame_buffer_bank.sv
// One frame of logit registers: indexed write, synchronous clear, flat parallel read.
module logit_bank
    import logit_frame_buffer_pkg::*;
(
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       we_i,
    input  logic [CNT_W-1:0]           idx_i,
    input  logic [DATA_W-1:0]          data_i,
    output logic [N_LOGITS*DATA_W-1:0] rd_o
);

    logic [DATA_W-1:0] mem_q [N_LOGITS];

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int i = 0; i < N_LOGITS; i++) begin
                mem_q[i] <= '0;
            end
        end else if (we_i && (idx_i <= LAST_IDX)) begin
            mem_q[idx_i] <= data_i;
        end
    end

    for (genvar g = 0; g < N_LOGITS; g++) begin : g_rd
        assign rd_o[g*DATA_W +: DATA_W] = mem_q[g];
    end

endmodule

// File: rtl/logit_frame_buffer.sv
// Ping-pong deserializer: fills one bank from the logit stream while the
// other bank is held stable for the argmax stage until it signals done.
module logit_frame_buffer
    import logit_frame_buffer_pkg::*;
(
    input  logic         clk,
    input  logic         rst_n,
    logit_frame_buffer_if.slave bus
);

    logic             wr_bank_q, wr_bank_d;
    logic             rd_bank_q, rd_bank_d;
    logic [1:0]       full_q, full_d;
    logic [CNT_W-1:0] wr_cnt_q, wr_cnt_d;
    pstate_e          state_q, state_d;
    logic             valid_out_q;
    logic             frame_err_q;

    logic in_ready;
    logic accept;
    logic at_last;
    logic frame_ok;
    logic framing_err;
    logic present;
    logic release_fr;

    logic [N_LOGITS*DATA_W-1:0] rd0, rd1, rd_sel;

    // Fill side
    always_comb begin
        in_ready    = rst_n && !full_q[wr_bank_q];
        accept      = bus.in_valid && in_ready;
        at_last     = (wr_cnt_q == LAST_IDX);
        frame_ok    = accept && at_last && bus.in_last;
        framing_err = accept && (bus.in_last != at_last);
    end

    // Fill completion and release always target different banks, so both apply.
    always_comb begin
        wr_cnt_d  = wr_cnt_q;
        wr_bank_d = wr_bank_q;
        rd_bank_d = rd_bank_q;
        full_d    = full_q;
        if (accept) begin
            wr_cnt_d = (frame_ok || framing_err) ? '0 : wr_cnt_q + CNT_W'(1);
        end
        if (frame_ok) begin
            full_d[wr_bank_q] = 1'b1;
            wr_bank_d         = ~wr_bank_q;
        end
        if (release_fr) begin
            full_d[rd_bank_q] = 1'b0;
            rd_bank_d         = ~rd_bank_q;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wr_bank_q   <= 1'b0;
            rd_bank_q   <= 1'b0;
            full_q      <= '0;
            wr_cnt_q    <= '0;
            frame_err_q <= 1'b0;
            valid_out_q <= 1'b0;
        end else begin
            wr_bank_q   <= wr_bank_d;
            rd_bank_q   <= rd_bank_d;
            full_q      <= full_d;
            wr_cnt_q    <= wr_cnt_d;
            frame_err_q <= framing_err;
            valid_out_q <= present;
        end
    end

    // Presenter FSM: state register
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= P_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            P_IDLE: if (full_q[rd_bank_q]) state_d = P_WAIT;
            P_WAIT: if (bus.done_in)       state_d = P_IDLE;
            default: state_d = P_IDLE;
        endcase
    end

    always_comb begin
        present    = (state_q == P_IDLE) && full_q[rd_bank_q];
        release_fr = (state_q == P_WAIT) && bus.done_in;
    end

    logit_bank u_bank0 (
        .clk    (clk),
        .rst_n  (rst_n),
        .we_i   (accept && !wr_bank_q),
        .idx_i  (wr_cnt_q),
        .data_i (bus.in_data),
        .rd_o   (rd0)
    );

    logit_bank u_bank1 (
        .clk    (clk),
        .rst_n  (rst_n),
        .we_i   (accept && wr_bank_q),
        .idx_i  (wr_cnt_q),
        .data_i (bus.in_data),
        .rd_o   (rd1)
    );

    // The held bank is never written, so the mux output is stable during hold.
    assign rd_sel = rd_bank_q ? rd1 : rd0;

    assign bus.logit0    = rd_sel[0*DATA_W +: DATA_W];
    assign bus.logit1    = rd_sel[1*DATA_W +: DATA_W];
    assign bus.logit2    = rd_sel[2*DATA_W +: DATA_W];
    assign bus.logit3    = rd_sel[3*DATA_W +: DATA_W];
    assign bus.logit4    = rd_sel[4*DATA_W +: DATA_W];
    assign bus.logit5    = rd_sel[5*DATA_W +: DATA_W];
    assign bus.logit6    = rd_sel[6*DATA_W +: DATA_W];
    assign bus.logit7    = rd_sel[7*DATA_W +: DATA_W];
    assign bus.logit8    = rd_sel[8*DATA_W +: DATA_W];
    assign bus.logit9    = rd_sel[9*DATA_W +: DATA_W];
    assign bus.in_ready  = in_ready;
    assign bus.valid_out = valid_out_q;
    assign bus.frame_err = frame_err_q;

endmodule
